dec_onehot_seq: RTL and testbench
=================================

Name: dec_onehot_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. It is the sequential successor of the team's 2-to-4 combinational decoder.
- Adds a valid/ready command interface and four modes: level (hold), single-cycle pulse, timed scan sweep, and clear.
- Sits between control logic and per-channel strobes/enables, e.g. row select, LED multiplexing, or channel gating.

Parameters:
- SEL_W, 2, select width; the block has 2^SEL_W outputs.
- OUT_W, 1<<SEL_W, output count. Derived value; do not override.
- SCAN_DWELL, 4, cycles each output stays asserted in scan mode. Must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- in_sel  in  SEL_W  output index; in scan mode, the start index.
- in_mode  in  2  command mode: 00 LEVEL, 01 PULSE, 10 SCAN, 11 CLEAR.
- scan_abort  in  1  terminates a scan in progress.
- out_onehot  out  OUT_W  bit i high means index i is selected.
- out_valid  out  1  high whenever out_onehot is non-zero.
- busy  out  1  high while in SCAN state.

Behaviour:
- Reset (asynchronous, immediate, including mid-scan):
  - out_onehot=0, out_valid=0, busy=0, in_ready=1.
  - State IDLE; all counters 0.
- Accept rule: a command is accepted on a clk edge where in_valid && in_ready. All outputs are registered; latency from accept to out_onehot is 1 cycle.
- Invariant: out_onehot has at most one bit set every cycle. out_valid == |out_onehot.
- States: IDLE, HOLD, PULSE, SCAN. in_ready = (state != SCAN); busy = (state == SCAN). Both are derived from the registered state.
- LEVEL command:
  - Next cycle out_onehot = 1<<in_sel; state HOLD.
  - Output is held until the next accepted command.
  - A new LEVEL command in HOLD replaces the selection with no zero gap cycle.
- PULSE command:
  - Next cycle out_onehot = 1<<in_sel for exactly one cycle; state PULSE.
  - Following cycle: out_onehot=0, state IDLE, unless another command is accepted in that PULSE cycle, in which case that command takes effect.
  - Back-to-back pulses at one per cycle are legal and produce a continuous one-hot stream.
- SCAN command:
  - State SCAN; index idx = in_sel; dwell counter = 0; visit counter = 0.
  - out_onehot = 1<<idx for SCAN_DWELL consecutive cycles.
  - idx then increments modulo OUT_W, wrapping from OUT_W-1 to 0.
  - After OUT_W indices have been visited, the next cycle is IDLE with out_onehot=0.
  - Total asserted cycles = OUT_W*SCAN_DWELL.
  - in_ready=0 for the whole scan, so commands are not accepted. in_ready returns to 1 in the first IDLE cycle.
- CLEAR command: next cycle out_onehot=0, state IDLE.
- scan_abort:
  - In SCAN: next cycle out_onehot=0, state IDLE, counters cleared.
  - Abort wins over natural scan completion in the same cycle; the result is identical (IDLE).
  - Outside SCAN: ignored.
- Width rules:
  - Dwell counter width is $clog2(SCAN_DWELL+1).
  - Visit counter width is SEL_W+1.
  - idx is SEL_W bits; natural overflow provides the wrap.
- Leaving HOLD via PULSE or SCAN transfers directly to the new pattern in the next cycle. There is no zero cycle.

Decomposition:
- Package dec_pkg:
  - mode_e enum: LEVEL=2'b00, PULSE=2'b01, SCAN=2'b10, CLEAR=2'b11.
  - state_e enum: IDLE, HOLD, PULSE, SCAN.
- One sub-module, dec_onehot_comb: purely combinational SEL_W to 2^SEL_W decoder with an enable input. The top instantiates it on the next-index value, then registers the result.

Test Plan (SEL_W=2, SCAN_DWELL=2):
- Reset then LEVEL sel=2 → out_onehot=4'b0100 one cycle after accept and held. LEVEL sel=1 then gives 4'b0010 with no zero cycle.
- PULSE sel=3 single → exactly one cycle of 4'b1000, then 0. Then 4 back-to-back PULSEs sel=0,1,2,3 → 0001, 0010, 0100, 1000 on consecutive cycles.
- SCAN sel=2 → 0100 ×2, 1000 ×2, 0001 ×2, 0010 ×2, then 0. busy=1 and in_ready=0 for 8 cycles; a LEVEL offered mid-scan is ignored.
- SCAN sel=0, assert scan_abort on cycle 3 → out_onehot=0 and busy=0 on the next cycle; in_ready=1.
- LEVEL sel=1, then CLEAR → 4'b0000, out_valid=0. scan_abort in IDLE has no effect.
- rst_n driven low asynchronously mid-scan (between clock edges) → outputs 0 immediately. After release, LEVEL sel=3 → 1000 one cycle later.
- Every scenario: checker asserts popcount(out_onehot)<=1 and out_valid==|out_onehot.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types for the registered one-hot decoder: command modes and FSM states.
package dec_pkg;

    // Command encoding carried on in_mode.
    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Controller states; in_ready and busy are decoded from these.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_HOLD  = 2'b01,
        S_PULSE = 2'b10,
        S_SCAN  = 2'b11
    } state_e;

endpackage

// File: rtl/dec_onehot_comb.sv
// Combinational SEL_W to 2^SEL_W one-hot decoder with enable.
module dec_onehot_comb #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    // Drive exactly one bit when enabled, otherwise all zero.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with a valid/ready command port and
// level / pulse / scan / clear modes. Handshake: a command transfers on a
// rising clk edge where in_valid && in_ready; in_ready is low only while
// scanning, and the new pattern appears on out_onehot one cycle later.
module dec_onehot_seq
    import dec_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int OUT_W      = 1 << SEL_W,
    parameter int SCAN_DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    input  logic             scan_abort,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic             busy
);

    localparam int DW = $clog2(SCAN_DWELL + 1);
    localparam int VW = SEL_W + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [VW-1:0] VISIT_LAST = VW'(OUT_W - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [VW-1:0]    visit_q, visit_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;

    logic             accept;
    logic             dec_en;
    logic [SEL_W-1:0] dec_sel;
    mode_e            mode;

    assign mode     = mode_e'(in_mode);
    assign in_ready = (state_q != S_SCAN);
    assign busy     = (state_q == S_SCAN);
    assign accept   = in_valid && in_ready;

    // Next-state, counters and the index/enable fed to the decoder.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        visit_d = visit_q;
        dec_en  = 1'b0;
        dec_sel = idx_q;
        case (state_q)
            S_SCAN: begin
                if (scan_abort) begin
                    // Abort takes priority over a natural completion.
                    state_d = S_IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                    visit_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    if (visit_q == VISIT_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        dwell_d = '0;
                        visit_d = '0;
                    end else begin
                        // idx wraps naturally at OUT_W.
                        idx_d   = idx_q + 1'b1;
                        dwell_d = '0;
                        visit_d = visit_q + 1'b1;
                        dec_en  = 1'b1;
                        dec_sel = idx_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                    dec_en  = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    idx_d   = in_sel;
                    dec_sel = in_sel;
                    dwell_d = '0;
                    visit_d = '0;
                    case (mode)
                        MODE_LEVEL: begin
                            state_d = S_HOLD;
                            dec_en  = 1'b1;
                        end
                        MODE_PULSE: begin
                            state_d = S_PULSE;
                            dec_en  = 1'b1;
                        end
                        MODE_SCAN: begin
                            state_d = S_SCAN;
                            dec_en  = 1'b1;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else if (state_q == S_HOLD) begin
                    dec_en = 1'b1;
                end else begin
                    // A pulse lasts one cycle; IDLE simply stays idle.
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    dec_onehot_comb #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .en     (dec_en),
        .sel    (dec_sel),
        .onehot (onehot_d)
    );

    // State, counters and the registered one-hot output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            visit_q  <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            visit_q  <= visit_d;
            onehot_q <= onehot_d;
        end
    end

    assign out_onehot = onehot_q;
    assign out_valid  = |onehot_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed bench for dec_onehot_seq (SEL_W=2, SCAN_DWELL=2).
module tb_dec_onehot_seq;

    localparam logic [1:0] M_LEVEL = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [1:0] in_mode;
    logic       scan_abort;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       busy;

    // Expected entry: {busy, in_ready, out_onehot}
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int step     = 0;

    dec_onehot_seq #(
        .SEL_W      (2),
        .SCAN_DWELL (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_mode    (in_mode),
        .scan_abort (scan_abort),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] e(input logic b, input logic r, input logic [3:0] oh);
        return {b, r, oh};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, expv);
    endtask

    // Compare all visible outputs against one expected entry.
    task automatic check_outputs(input logic [5:0] expv);
        check("onehot",    {4'h0, out_onehot}, {4'h0, expv[3:0]});
        check("in_ready",  {7'h0, in_ready},   {7'h0, expv[4]});
        check("busy",      {7'h0, busy},       {7'h0, expv[5]});
        check("out_valid", {7'h0, out_valid},  {7'h0, |expv[3:0]});
        check("popcount_le1", {7'h0, ($countones(out_onehot) <= 1)}, 8'h01);
        check("valid_eq_or",  {7'h0, out_valid}, {7'h0, |out_onehot});
    endtask

    // Drive one cycle of stimulus, push its expected result, compare after the edge.
    task automatic cycle(input logic v, input logic [1:0] m, input logic [1:0] s,
                         input logic ab, input logic [5:0] expv);
        logic [5:0] got;
        in_valid   = v;
        in_mode    = m;
        in_sel     = s;
        scan_abort = ab;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        scan_abort = 1'b0;
        step++;
        got = exp_q.pop_front();
        check_outputs(got);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 2'd0;
        in_mode    = M_LEVEL;
        scan_abort = 1'b0;

        // Reset state
        #12;
        check_outputs(e(0, 1, 4'b0000));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(e(0, 1, 4'b0000));

        // LEVEL hold and replacement without a zero cycle
        cycle(1, M_LEVEL, 2'd2, 0, e(0, 1, 4'b0100));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0100));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0100));
        cycle(1, M_LEVEL, 2'd1, 0, e(0, 1, 4'b0010));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0010));

        // Single pulse from HOLD, then back to zero
        cycle(1, M_PULSE, 2'd3, 0, e(0, 1, 4'b1000));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0000));

        // Back-to-back pulses
        for (int i = 0; i < 4; i++) begin
            cycle(1, M_PULSE, 2'(i), 0, e(0, 1, 4'(1 << i)));
        end
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0000));

        // Command accepted during a PULSE cycle takes effect
        cycle(1, M_PULSE, 2'd0, 0, e(0, 1, 4'b0001));
        cycle(1, M_LEVEL, 2'd2, 0, e(0, 1, 4'b0100));

        // Full scan from index 2, LEVEL offered mid-scan is ignored
        cycle(1, M_SCAN,  2'd2, 0, e(1, 0, 4'b0100));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0100));
        cycle(1, M_LEVEL, 2'd0, 0, e(1, 0, 4'b1000));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b1000));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0001));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0001));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0010));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0010));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0000));

        // Scan from 0 aborted on its third cycle
        cycle(1, M_SCAN,  2'd0, 0, e(1, 0, 4'b0001));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0001));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0010));
        cycle(0, M_LEVEL, 2'd0, 1, e(0, 1, 4'b0000));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b0000));

        // LEVEL then CLEAR; abort outside SCAN is ignored
        cycle(1, M_LEVEL, 2'd1, 0, e(0, 1, 4'b0010));
        cycle(1, M_CLEAR, 2'd2, 0, e(0, 1, 4'b0000));
        cycle(0, M_LEVEL, 2'd0, 1, e(0, 1, 4'b0000));
        cycle(1, M_LEVEL, 2'd3, 0, e(0, 1, 4'b1000));
        cycle(0, M_LEVEL, 2'd0, 1, e(0, 1, 4'b1000));

        // HOLD straight into SCAN, then asynchronous reset mid-scan
        cycle(1, M_SCAN,  2'd1, 0, e(1, 0, 4'b0010));
        cycle(0, M_LEVEL, 2'd0, 0, e(1, 0, 4'b0010));
        #3;
        rst_n = 1'b0;
        #1;
        step++;
        check_outputs(e(0, 1, 4'b0000));
        @(negedge clk);
        check_outputs(e(0, 1, 4'b0000));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step++;
        check_outputs(e(0, 1, 4'b0000));
        cycle(1, M_LEVEL, 2'd3, 0, e(0, 1, 4'b1000));
        cycle(0, M_LEVEL, 2'd0, 0, e(0, 1, 4'b1000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
